spdif_decoder: RTL and testbench
================================

Name: spdif_decoder

Overview:
- Receives a raw S/PDIF (IEC 60958) biphase-mark stream, oversampled by the system clock (38.4 MHz nominal, 48 kHz / 3.072 Mbit/s stream).
- Recovers preambles and subframes, and outputs decoded 24-bit left/right samples with status flags.
- Sits between the S/PDIF input pin and the I2S transmitter; the bit-clock divider and I2S serialiser are separate blocks.

Parameters:
- SHORT_MAX, 9: longest edge interval, in clk cycles, classed as a half cell (nominal 6.25).
- MED_MAX, 15: longest interval classed as a full cell (nominal 12.5); above this is a 1.5-cell preamble pulse (nominal 18.75).
- LONG_MAX, 24: longest valid interval; longer means signal loss.
- CNT_W, 6: interval counter width; must hold LONG_MAX+1.

Ports:
- clk, in, 1: system clock, 38.4 MHz.
- reset, in, 1: asynchronous, active-low reset.
- spdif, in, 1: asynchronous S/PDIF line.
- sample_left, out, 24: last complete left sample, MSB-aligned; aux bits are the 4 LSBs.
- sample_right, out, 24: last complete right sample.
- sample_strobe, out, 1: one-cycle pulse when sample_right updates (left/right pair complete).
- block_start, out, 1: one-cycle pulse on a B preamble.
- chan_status, out, 1: C bit of the most recent subframe.
- parity_err, out, 1: sticky until the next good subframe; set when even parity over slots 4..31 fails.
- locked, out, 1: high after 2 consecutive well-formed subframes; low on any framing error.

Behaviour:
- Reset (reset=0, async): all outputs, counters and state are 0.
- Synchroniser: spdif passes through a 2-FF synchroniser, then an edge detector. Total input latency is 3 clk.
- Interval counter:
  - Counts clk cycles between edges and saturates at LONG_MAX+1.
  - Each edge classifies the interval as S (≤SHORT_MAX), M (≤MED_MAX), L (≤LONG_MAX) or X (greater).
- FSM states: HUNT, PRE1, PRE2, PRE3, DATA.
- HUNT: an L interval moves to PRE1.
- Preamble decode, after the first L, matched on the next three intervals in half-cell units:
  - B = L,S,S,L (1.5,0.5,0.5,1.5).
  - M = L,L,S,S.
  - W = L,M,S,M.
  - Any other sequence → HUNT, with locked=0.
- DATA:
  - Decodes 28 slots (4..31). M = 0. S followed by S = 1.
  - A single S followed by M or L, any L, or X → HUNT, with locked=0.
- Slot usage:
  - Slots 4..27 are shifted LSB-first into a 24-bit register.
  - Slot 28 = V (ignored), slot 29 = U (ignored), slot 30 = C, slot 31 = P.
- End of subframe:
  - Check parity.
  - B or M subframe: load sample_left. W subframe: load sample_right and pulse sample_strobe.
  - Both loads happen one cycle after the final interval is classified.
  - A parity error still loads the sample but sets parity_err.
- block_start pulses on the cycle the B preamble is recognised.
- Signal loss: X interval (no edge for more than LONG_MAX cycles) → HUNT, locked=0. The counter stays saturated and never wraps.
- A W subframe without a preceding left subframe in lock produces no sample_strobe.
- An edge on the same cycle as counter saturation counts as X.
- Reset mid-frame aborts the frame immediately; no partial sample is output.

Decomposition:
- Package spdif_pkg:
  - interval-class enum (S, M, L, X);
  - preamble enum (PRE_B, PRE_M, PRE_W);
  - slot constants (AUDIO_FIRST=4, AUDIO_LAST=27, SLOT_C=30, SLOT_P=31).
- One natural sub-module: spdif_edge_timer (synchroniser, edge detect, interval counter, classifier).
- FSM and shift register stay in spdif_decoder.

Test Plan:
- Hold reset low for 3 clk with spdif toggling → all outputs 0; after release with idle line, locked stays 0.
- 162 ns half-cell stream, B+W pair with left=0xAAFF00, right=0x000000, correct parity → sample_left=0xAAFF00, sample_right=0, sample_strobe pulses once, block_start pulses once, locked=1 after 2 subframes.
- Same stream with the P bit flipped in the left subframe → parity_err=1, sample still loaded; next good subframe clears it.
- Line held constant for 1 µs mid-subframe → locked=0, no strobe; resumes and re-locks on the next valid preamble.
- Illegal preamble sequence L,S,L,S → FSM returns to HUNT, no sample update.
- Bit-period jitter ±1 clk on every interval → decoded samples identical to the jitter-free case.

Source files
------------

// File: rtl/spdif_pkg.sv
//------------------------------------------------------------------------------
// Module   : spdif_pkg
// Brief    : Shared types and slot constants for the S/PDIF receive path.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package spdif_pkg;

  typedef enum logic [1:0] {
    IVL_S = 2'd0,
    IVL_M = 2'd1,
    IVL_L = 2'd2,
    IVL_X = 2'd3
  } ivl_t;

  typedef enum logic [1:0] {
    PRE_B = 2'd0,
    PRE_M = 2'd1,
    PRE_W = 2'd2
  } pre_t;

  typedef enum logic [2:0] {
    ST_HUNT = 3'd0,
    ST_PRE1 = 3'd1,
    ST_PRE2 = 3'd2,
    ST_PRE3 = 3'd3,
    ST_DATA = 3'd4
  } state_t;

  localparam logic [4:0] AUDIO_FIRST = 5'd4;
  localparam logic [4:0] AUDIO_LAST  = 5'd27;
  localparam logic [4:0] SLOT_C      = 5'd30;
  localparam logic [4:0] SLOT_P      = 5'd31;

endpackage

`default_nettype wire

// File: rtl/spdif_if.sv
//------------------------------------------------------------------------------
// Module   : spdif_if
// Brief    : S/PDIF line input and decoded sample/status bundle.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface spdif_if;
  logic        spdif;
  logic [23:0] sample_left;
  logic [23:0] sample_right;
  logic        sample_strobe;
  logic        block_start;
  logic        chan_status;
  logic        parity_err;
  logic        locked;

  modport slave (
    input  spdif,
    output sample_left, sample_right, sample_strobe, block_start,
    output chan_status, parity_err, locked
  );

  modport master (
    output spdif,
    input  sample_left, sample_right, sample_strobe, block_start,
    input  chan_status, parity_err, locked
  );
endinterface

`default_nettype wire

// File: rtl/spdif_edge_timer.sv
//------------------------------------------------------------------------------
// Module   : spdif_edge_timer
// Brief    : Synchronises the line, times edge-to-edge intervals, classifies
//            them as S/M/L/X and emits one registered event per interval.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module spdif_edge_timer
  import spdif_pkg::*;
#(
  parameter int unsigned SHORT_MAX = 9,
  parameter int unsigned MED_MAX   = 15,
  parameter int unsigned LONG_MAX  = 24,
  parameter int unsigned CNT_W     = 6
) (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic i_spdif,
  output logic      o_valid,
  output ivl_t      o_cls
);

  localparam logic [CNT_W-1:0] C_SHORT = CNT_W'(SHORT_MAX);
  localparam logic [CNT_W-1:0] C_MED   = CNT_W'(MED_MAX);
  localparam logic [CNT_W-1:0] C_LONG  = CNT_W'(LONG_MAX);
  localparam logic [CNT_W-1:0] C_SAT   = CNT_W'(LONG_MAX + 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_sync3;
  logic [CNT_W-1:0] r_cnt;
  logic             r_valid;
  ivl_t             r_cls;

  logic             w_edge;
  logic             w_loss;
  ivl_t             w_cls;

  assign w_edge = r_sync2 ^ r_sync3;
  // Reaching saturation without an edge is reported once as an X interval.
  assign w_loss = !w_edge && (r_cnt == C_LONG);

  always_comb begin
    w_cls = IVL_X;
    if (r_cnt <= C_SHORT)     w_cls = IVL_S;
    else if (r_cnt <= C_MED)  w_cls = IVL_M;
    else if (r_cnt <= C_LONG) w_cls = IVL_L;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_cls   <= IVL_S;
    end else begin
      r_sync1 <= i_spdif;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      if (w_edge)              r_cnt <= CNT_W'(1);
      else if (r_cnt != C_SAT) r_cnt <= r_cnt + 1'b1;
      r_valid <= w_edge | w_loss;
      r_cls   <= w_loss ? IVL_X : w_cls;
    end
  end

  assign o_valid = r_valid;
  assign o_cls   = r_cls;

endmodule

`default_nettype wire

// File: rtl/spdif_decoder.sv
//------------------------------------------------------------------------------
// Module   : spdif_decoder
// Brief    : Biphase-mark S/PDIF receiver: preamble/slot decode to 24-bit
//            left/right samples with block, channel-status and parity flags.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module spdif_decoder
  import spdif_pkg::*;
#(
  parameter int unsigned SHORT_MAX = 9,
  parameter int unsigned MED_MAX   = 15,
  parameter int unsigned LONG_MAX  = 24,
  parameter int unsigned CNT_W     = 6
) (
  input  wire logic clk,
  input  wire logic reset,
  spdif_if.slave    bus
);

  logic        w_valid;
  ivl_t        w_cls;

  state_t      r_state;
  pre_t        r_pre;
  logic        r_half;
  logic [4:0]  r_slot;
  logic [23:0] r_shift;
  logic        r_par;
  logic        r_c;
  logic        r_left_ok;
  logic [1:0]  r_good;
  logic [23:0] r_left;
  logic [23:0] r_right;
  logic        r_strobe;
  logic        r_block;
  logic        r_chan;
  logic        r_perr;
  logic        r_locked;

  state_t      w_state_nxt;
  pre_t        w_pre_nxt;
  logic        w_half_nxt;
  logic        w_bit_vld;
  logic        w_bit;
  logic        w_err;
  logic        w_pre_ok;
  logic        w_last;

  spdif_edge_timer #(
    .SHORT_MAX (SHORT_MAX),
    .MED_MAX   (MED_MAX),
    .LONG_MAX  (LONG_MAX),
    .CNT_W     (CNT_W)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .i_spdif (bus.spdif),
    .o_valid (w_valid),
    .o_cls   (w_cls)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_HUNT;
      r_pre   <= PRE_B;
      r_half  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pre   <= w_pre_nxt;
      r_half  <= w_half_nxt;
    end
  end

  // Preamble intervals in half cells: B=3,1,1,3  M=3,3,1,1  W=3,2,1,2.
  always_comb begin
    w_state_nxt = r_state;
    w_pre_nxt   = r_pre;
    w_half_nxt  = r_half;
    w_bit_vld   = 1'b0;
    w_bit       = 1'b0;
    w_err       = 1'b0;
    w_pre_ok    = 1'b0;
    if (w_valid) begin
      case (r_state)
        ST_HUNT: begin
          if (w_cls == IVL_L) w_state_nxt = ST_PRE1;
          else                w_err       = 1'b1;
        end
        ST_PRE1: begin
          w_state_nxt = ST_PRE2;
          case (w_cls)
            IVL_S:   w_pre_nxt = PRE_B;
            IVL_L:   w_pre_nxt = PRE_M;
            IVL_M:   w_pre_nxt = PRE_W;
            default: begin
              w_err       = 1'b1;
              w_state_nxt = ST_HUNT;
            end
          endcase
        end
        ST_PRE2: begin
          if (w_cls == IVL_S) begin
            w_state_nxt = ST_PRE3;
          end else begin
            w_err       = 1'b1;
            w_state_nxt = ST_HUNT;
          end
        end
        ST_PRE3: begin
          if ((r_pre == PRE_B && w_cls == IVL_L) ||
              (r_pre == PRE_M && w_cls == IVL_S) ||
              (r_pre == PRE_W && w_cls == IVL_M)) begin
            w_state_nxt = ST_DATA;
            w_pre_ok    = 1'b1;
            w_half_nxt  = 1'b0;
          end else begin
            w_err       = 1'b1;
            w_state_nxt = ST_HUNT;
          end
        end
        ST_DATA: begin
          if (r_half) begin
            w_half_nxt = 1'b0;
            if (w_cls == IVL_S) begin
              w_bit_vld = 1'b1;
              w_bit     = 1'b1;
            end else begin
              w_err       = 1'b1;
              w_state_nxt = ST_HUNT;
            end
          end else begin
            case (w_cls)
              IVL_S:   w_half_nxt = 1'b1;
              IVL_M:   w_bit_vld  = 1'b1;
              default: begin
                w_err       = 1'b1;
                w_state_nxt = ST_HUNT;
              end
            endcase
          end
        end
        default: w_state_nxt = ST_HUNT;
      endcase
    end
    w_last = w_bit_vld && (r_slot == SLOT_P);
    if (w_last) w_state_nxt = ST_HUNT;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_slot    <= '0;
      r_shift   <= '0;
      r_par     <= 1'b0;
      r_c       <= 1'b0;
      r_left_ok <= 1'b0;
      r_good    <= '0;
      r_left    <= '0;
      r_right   <= '0;
      r_strobe  <= 1'b0;
      r_block   <= 1'b0;
      r_chan    <= 1'b0;
      r_perr    <= 1'b0;
      r_locked  <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      r_block  <= w_pre_ok && (r_pre == PRE_B);
      if (w_pre_ok) begin
        r_slot <= AUDIO_FIRST;
        r_par  <= 1'b0;
      end
      if (w_bit_vld) begin
        r_slot <= r_slot + 5'd1;
        r_par  <= r_par ^ w_bit;
        if (r_slot <= AUDIO_LAST) r_shift <= {w_bit, r_shift[23:1]};
        if (r_slot == SLOT_C)     r_c     <= w_bit;
      end
      if (w_last) begin
        r_chan <= r_c;
        r_perr <= r_par ^ w_bit;
        if (r_pre != PRE_W) begin
          r_left    <= r_shift;
          r_left_ok <= 1'b1;
        end else if (r_left_ok) begin
          // A right sample is only published when it completes a pair.
          r_right   <= r_shift;
          r_strobe  <= 1'b1;
          r_left_ok <= 1'b0;
        end
        if (r_good != 2'd2) r_good <= r_good + 2'd1;
        r_locked <= (r_good != 2'd0);
      end
      if (w_err) begin
        r_good    <= '0;
        r_locked  <= 1'b0;
        r_left_ok <= 1'b0;
      end
    end
  end

  assign bus.sample_left   = r_left;
  assign bus.sample_right  = r_right;
  assign bus.sample_strobe = r_strobe;
  assign bus.block_start   = r_block;
  assign bus.chan_status   = r_chan;
  assign bus.parity_err    = r_perr;
  assign bus.locked        = r_locked;

endmodule

`default_nettype wire

// File: tb/tb_spdif_decoder.sv
//------------------------------------------------------------------------------
// Module   : tb_spdif_decoder
// Brief    : Self-checking bench for spdif_decoder driven by a timed
//            biphase-mark line model and a subframe-level reference model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_spdif_decoder;
  import spdif_pkg::*;

  localparam int CLK    = 26;
  localparam int HC     = 162;
  localparam int SETTLE = 6 * CLK;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  spdif_if u_if ();

  spdif_decoder u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if.slave)
  );

  always #13 clk = ~clk;

  int n_tests    = 0;
  int n_fail     = 0;
  int cnt_strobe = 0;
  int cnt_block  = 0;
  int elapsed    = 0;
  bit jit_en     = 1'b0;

  always @(negedge clk) begin
    if (u_if.sample_strobe) cnt_strobe++;
    if (u_if.block_start)   cnt_block++;
  end

  // Reference model state, updated once per transmitted subframe.
  logic [23:0] m_left, m_right;
  bit          m_perr, m_chan, m_locked, m_left_ok;
  int          m_good, m_strobes, m_blocks;

  typedef struct {
    pre_t        pre;
    logic [23:0] data;
    bit          c;
    bit          pflip;
    logic [23:0] e_left;
    logic [23:0] e_right;
    bit          e_perr;
    bit          e_chan;
    bit          e_locked;
    int          e_str;
    int          e_blk;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic edge_after(input int halves);
    int d;
    d = halves * HC;
    if (jit_en) d = d + int'($urandom_range(0, 52)) - 26;
    d = d - elapsed;
    elapsed = 0;
    #(d);
    u_if.spdif = ~u_if.spdif;
  endtask

  task automatic settle();
    #(SETTLE);
    elapsed = elapsed + SETTLE;
  endtask

  task automatic lead_in();
    #(200);
    u_if.spdif = ~u_if.spdif;
    elapsed = 0;
  endtask

  function automatic logic [27:0] mk_word(input logic [23:0] data, input bit c, input bit pflip);
    logic p;
    p = (^data) ^ c ^ pflip;
    return {p, c, 1'b0, 1'b0, data};
  endfunction

  task automatic send_pre(input pre_t p);
    case (p)
      PRE_B:   begin edge_after(3); edge_after(1); edge_after(1); edge_after(3); end
      PRE_M:   begin edge_after(3); edge_after(3); edge_after(1); edge_after(1); end
      default: begin edge_after(3); edge_after(2); edge_after(1); edge_after(2); end
    endcase
  endtask

  task automatic send_bits(input logic [27:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      if (w[i]) begin
        edge_after(1);
        edge_after(1);
      end else begin
        edge_after(2);
      end
    end
  endtask

  task automatic send_sub(input pre_t p, input logic [23:0] data, input bit c, input bit pflip);
    send_pre(p);
    send_bits(mk_word(data, c, pflip), 28);
    settle();
  endtask

  task automatic model_sub(input pre_t p, input logic [23:0] data, input bit c, input bit pflip);
    if (p == PRE_B) m_blocks++;
    if (p != PRE_W) begin
      m_left    = data;
      m_left_ok = 1'b1;
    end else if (m_left_ok) begin
      m_right   = data;
      m_strobes++;
      m_left_ok = 1'b0;
    end
    m_perr   = pflip;
    m_chan   = c;
    m_good   = (m_good >= 2) ? 2 : m_good + 1;
    m_locked = (m_good == 2);
  endtask

  task automatic model_break();
    m_good    = 0;
    m_locked  = 1'b0;
    m_left_ok = 1'b0;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_left"},   32'(u_if.sample_left),  32'(m_left));
    chk({tag, "_right"},  32'(u_if.sample_right), 32'(m_right));
    chk({tag, "_perr"},   32'(u_if.parity_err),   32'(m_perr));
    chk({tag, "_chan"},   32'(u_if.chan_status),  32'(m_chan));
    chk({tag, "_locked"}, 32'(u_if.locked),       32'(m_locked));
    chk({tag, "_strobes"}, cnt_strobe, m_strobes);
    chk({tag, "_blocks"},  cnt_block,  m_blocks);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_left"},   32'(u_if.sample_left),   0);
    chk({tag, "_right"},  32'(u_if.sample_right),  0);
    chk({tag, "_strobe"}, 32'(u_if.sample_strobe), 0);
    chk({tag, "_block"},  32'(u_if.block_start),   0);
    chk({tag, "_chan"},   32'(u_if.chan_status),   0);
    chk({tag, "_perr"},   32'(u_if.parity_err),    0);
    chk({tag, "_locked"}, 32'(u_if.locked),        0);
  endtask

  initial begin
    pre_t        lp;
    logic [23:0] d;
    bit          c, pf;

    vecs[0] = '{PRE_B, 24'hAAFF00, 1'b1, 1'b0, 24'hAAFF00, 24'h000000, 1'b0, 1'b1, 1'b0, 0, 1};
    vecs[1] = '{PRE_W, 24'h000000, 1'b0, 1'b0, 24'hAAFF00, 24'h000000, 1'b0, 1'b0, 1'b1, 1, 1};
    vecs[2] = '{PRE_M, 24'h123456, 1'b0, 1'b1, 24'h123456, 24'h000000, 1'b1, 1'b0, 1'b1, 1, 1};
    vecs[3] = '{PRE_W, 24'h654321, 1'b1, 1'b0, 24'h123456, 24'h654321, 1'b0, 1'b1, 1'b1, 2, 1};
    vecs[4] = '{PRE_B, 24'hAAFF00, 1'b0, 1'b1, 24'hAAFF00, 24'h654321, 1'b1, 1'b0, 1'b1, 2, 2};
    vecs[5] = '{PRE_W, 24'h000000, 1'b0, 1'b0, 24'hAAFF00, 24'h000000, 1'b0, 1'b0, 1'b1, 3, 2};

    m_left = '0; m_right = '0; m_perr = 0; m_chan = 0; m_locked = 0; m_left_ok = 0;
    m_good = 0; m_strobes = 0; m_blocks = 0;

    // Half-ns offset keeps every stimulus and check off the clock edges.
    u_if.spdif = 1'b0;
    #0.5;
    reset = 1'b0;
    repeat (3) begin
      #(CLK);
      u_if.spdif = ~u_if.spdif;
    end
    chk_zero("reset");
    reset = 1'b1;
    #(60 * CLK);
    chk_zero("idle");

    lead_in();
    for (int i = 0; i < 6; i++) begin
      send_sub(vecs[i].pre, vecs[i].data, vecs[i].c, vecs[i].pflip);
      model_sub(vecs[i].pre, vecs[i].data, vecs[i].c, vecs[i].pflip);
      chk($sformatf("vec%0d_left", i),   32'(u_if.sample_left),  32'(vecs[i].e_left));
      chk($sformatf("vec%0d_right", i),  32'(u_if.sample_right), 32'(vecs[i].e_right));
      chk($sformatf("vec%0d_perr", i),   32'(u_if.parity_err),   32'(vecs[i].e_perr));
      chk($sformatf("vec%0d_chan", i),   32'(u_if.chan_status),  32'(vecs[i].e_chan));
      chk($sformatf("vec%0d_locked", i), 32'(u_if.locked),       32'(vecs[i].e_locked));
      chk($sformatf("vec%0d_strobes", i), cnt_strobe, vecs[i].e_str);
      chk($sformatf("vec%0d_blocks", i),  cnt_block,  vecs[i].e_blk);
    end

    // Line frozen for 1 us inside a left subframe.
    send_pre(PRE_M);
    send_bits(mk_word(24'h5A5A5A, 1'b0, 1'b0), 10);
    #(1000);
    model_break();
    chk_model("gap");
    lead_in();
    send_sub(PRE_W, 24'h0F0F0F, 1'b0, 1'b0);
    model_sub(PRE_W, 24'h0F0F0F, 1'b0, 1'b0);
    chk_model("resync_w");
    send_sub(PRE_B, 24'h13579B, 1'b1, 1'b0);
    model_sub(PRE_B, 24'h13579B, 1'b1, 1'b0);
    chk_model("resync_b");
    send_sub(PRE_W, 24'hFEDCBA, 1'b0, 1'b0);
    model_sub(PRE_W, 24'hFEDCBA, 1'b0, 1'b0);
    chk_model("relock");

    // Illegal preamble L,S,L,S.
    edge_after(3); edge_after(1); edge_after(3); edge_after(1);
    settle();
    model_break();
    chk_model("illegal");
    send_sub(PRE_M, 24'h800001, 1'b1, 1'b0);
    model_sub(PRE_M, 24'h800001, 1'b1, 1'b0);
    chk_model("after_illegal_m");
    send_sub(PRE_W, 24'h7FFFFE, 1'b0, 1'b0);
    model_sub(PRE_W, 24'h7FFFFE, 1'b0, 1'b0);
    chk_model("after_illegal_w");

    // Random samples with +-1 clk jitter on every interval.
    jit_en = 1'b1;
    for (int k = 0; k < 12; k++) begin
      lp = ($urandom_range(0, 3) == 0) ? PRE_B : PRE_M;
      d  = 24'($urandom);
      c  = 1'($urandom_range(0, 1));
      pf = ($urandom_range(0, 3) == 0);
      send_sub(lp, d, c, pf);
      model_sub(lp, d, c, pf);
      chk_model($sformatf("rnd%0d_l", k));
      d  = 24'($urandom);
      c  = 1'($urandom_range(0, 1));
      pf = ($urandom_range(0, 3) == 0);
      send_sub(PRE_W, d, c, pf);
      model_sub(PRE_W, d, c, pf);
      chk_model($sformatf("rnd%0d_r", k));
    end

    // Reset asserted in the middle of a subframe.
    jit_en = 1'b0;
    send_pre(PRE_M);
    send_bits(mk_word(24'hC3C3C3, 1'b1, 1'b0), 6);
    #(2 * CLK);
    reset = 1'b0;
    #(2 * CLK);
    chk_zero("midreset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
